// File: rtl/ddr_rd_capture.sv
// Read-data capture and burst framing behind the DQ input DDR flops.
// A CAS-latency delay line marks the cycles that carry valid burst words.
module ddr_rd_capture #(
  parameter int DQ_WIDTH  = 16,
  parameter int BURST_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            cas_lat,
  input  logic                  rd_cmd,
  input  logic [DQ_WIDTH-1:0]   dq_q0,
  input  logic [DQ_WIDTH-1:0]   dq_q1,
  output logic [2*DQ_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic                  rd_busy,
  output logic                  rd_overrun
);

  localparam int N  = BURST_LEN / 2;
  localparam int CW = $clog2(N) + 1;

  logic [16:0]           dl_q, dl_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2*DQ_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  overrun_q, overrun_d;

  logic [3:0]  eff_cl;
  logic [4:0]  tap_idx;
  logic [16:0] tap_mask;
  logic        hit;
  logic        cnt_nz;
  logic        active;

  // Delay line beyond the selected tap can no longer produce a hit,
  // so only the taps up to eff_cl+1 keep the block busy.
  always_comb begin
    eff_cl   = (cas_lat < 4'd2) ? 4'd2 : cas_lat;
    tap_idx  = {1'b0, eff_cl} + 5'd1;
    hit      = dl_q[tap_idx];
    tap_mask = '0;
    for (int i = 0; i < 17; i++) begin
      tap_mask[i] = (5'(i) <= tap_idx);
    end
  end

  always_comb begin
    cnt_nz    = (cnt_q != '0);
    active    = hit | cnt_nz;
    dl_d      = {dl_q[15:0], rd_cmd};
    cnt_d     = cnt_q;
    if (hit) begin
      cnt_d = CW'(N - 1);
    end else if (cnt_nz) begin
      cnt_d = cnt_q - CW'(1);
    end
    overrun_d = overrun_q | (hit & cnt_nz);
    valid_d   = active;
    last_d    = active & ~hit & (cnt_q == CW'(1));
    data_d    = active ? {dq_q1, dq_q0} : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_q      <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      dl_q      <= dl_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
    end
  end

  assign rd_data    = data_q;
  assign rd_valid   = valid_q;
  assign rd_last    = last_q;
  assign rd_overrun = overrun_q;
  assign rd_busy    = (|(dl_q & tap_mask)) | (cnt_q != '0) | valid_q;

endmodule

// File: tb/tb_ddr_rd_capture.sv
// Directed bench for ddr_rd_capture: one instance per burst length,
// shared stimulus, expected values written out by hand per cycle.
module tb_ddr_rd_capture;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  cas_lat = 4'd3;
   logic        rd_cmd = 1'b0;
   logic [15:0] dq_q0 = '0;
   logic [15:0] dq_q1 = '0;

   logic [31:0] r4_data, r8_data;
   logic        r4_valid, r4_last, r4_busy, r4_overrun;
   logic        r8_valid, r8_last, r8_busy, r8_overrun;

   int cyc;
   int checks;
   int failures;

   ddr_rd_capture #(.DQ_WIDTH(16), .BURST_LEN(4)) u4 (
      .clk(clk), .rst_n(rst_n), .cas_lat(cas_lat), .rd_cmd(rd_cmd),
      .dq_q0(dq_q0), .dq_q1(dq_q1), .rd_data(r4_data), .rd_valid(r4_valid),
      .rd_last(r4_last), .rd_busy(r4_busy), .rd_overrun(r4_overrun)
   );

   ddr_rd_capture #(.DQ_WIDTH(16), .BURST_LEN(8)) u8 (
      .clk(clk), .rst_n(rst_n), .cas_lat(cas_lat), .rd_cmd(rd_cmd),
      .dq_q0(dq_q0), .dq_q1(dq_q1), .rd_data(r8_data), .rd_valid(r8_valid),
      .rd_last(r8_last), .rd_busy(r8_busy), .rd_overrun(r8_overrun)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   // Data pattern driven in cycle c; each word is unique per cycle
   function automatic logic [15:0] q0f(input int c);
      return 16'h0a00 + 16'(c);
   endfunction

   function automatic logic [15:0] q1f(input int c);
      return 16'hb000 + 16'(c);
   endfunction

   // Advance to just after the next rising edge, where outputs are stable
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Drive the command and the default data pattern for the current cycle
   task automatic applyStimulus(input logic cmd);
      rd_cmd = cmd;
      dq_q0  = q0f(cyc);
      dq_q1  = q1f(cyc);
   endtask

   // Single-bit comparison with failure accounting
   task automatic checkOutput(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("[TB] FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, expv);
      end
   endtask

   // Word comparison with failure accounting
   task automatic checkWord(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("[TB] FAIL %s cyc=%0d observed=%08h expected=%08h", tag, cyc, obs, expv);
      end
   endtask

   // Hold reset for two edges, confirm cleared outputs, then release
   task automatic doReset();
      rst_n  = 1'b0;
      rd_cmd = 1'b0;
      tick();
      tick();
      checkOutput("rst_valid4", r4_valid, 1'b0);
      checkOutput("rst_busy4", r4_busy, 1'b0);
      checkOutput("rst_ovr8", r8_overrun, 1'b0);
      checkWord("rst_data8", r8_data, 32'h0);
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   // Each section runs a fixed number of cycles, so the run always ends
   initial begin
      int cls[3];
      int effs[3];
      int t0;
      int e;
      checks   = 0;
      failures = 0;
      cyc      = 0;

      // Single read, BL4, CL3, command at cycle 10
      cas_lat = 4'd3;
      doReset();
      for (int k = 0; k < 20; k++) begin
         applyStimulus(cyc == 10);
         if (cyc == 15) begin dq_q0 = 16'h1111; dq_q1 = 16'h2222; end
         if (cyc == 16) begin dq_q0 = 16'h3333; dq_q1 = 16'h4444; end
         checkOutput("t1_valid", r4_valid, cyc == 16 || cyc == 17);
         checkOutput("t1_last", r4_last, cyc == 17);
         checkOutput("t1_busy", r4_busy, cyc >= 11 && cyc <= 17);
         checkOutput("t1_ovr", r4_overrun, 1'b0);
         if (cyc < 16)       checkWord("t1_data", r4_data, 32'h0);
         else if (cyc == 16) checkWord("t1_data", r4_data, 32'h22221111);
         else                checkWord("t1_data", r4_data, 32'h44443333);
         tick();
      end

      // CAS latency sweep on BL4: 0 behaves as 2, plus 2 and 15
      cls  = '{0, 2, 15};
      effs = '{2, 2, 15};
      for (int s = 0; s < 3; s++) begin
         cas_lat = 4'(cls[s]);
         doReset();
         t0 = 1;
         e  = effs[s];
         for (int k = 0; k < t0 + e + 7; k++) begin
            applyStimulus(cyc == t0);
            checkOutput("cl_valid", r4_valid, cyc >= t0 + e + 3 && cyc <= t0 + e + 4);
            checkOutput("cl_last", r4_last, cyc == t0 + e + 4);
            if (cyc >= t0 + e + 3 && cyc <= t0 + e + 4)
               checkWord("cl_data", r4_data, {q1f(cyc - 1), q0f(cyc - 1)});
            tick();
         end
      end

      // Gapless BL8, CL5, commands at cycles 0 and 4
      cas_lat = 4'd5;
      doReset();
      for (int k = 0; k < 19; k++) begin
         applyStimulus(cyc == 0 || cyc == 4);
         checkOutput("gap_valid", r8_valid, cyc >= 8 && cyc <= 15);
         checkOutput("gap_last", r8_last, cyc == 11 || cyc == 15);
         checkOutput("gap_busy", r8_busy, cyc >= 1 && cyc <= 15);
         checkOutput("gap_ovr", r8_overrun, 1'b0);
         if (cyc >= 8 && cyc <= 15)
            checkWord("gap_data", r8_data, {q1f(cyc - 1), q0f(cyc - 1)});
         tick();
      end

      // Overrun BL8, CL5, commands at cycles 0 and 3
      cas_lat = 4'd5;
      doReset();
      for (int k = 0; k < 18; k++) begin
         applyStimulus(cyc == 0 || cyc == 3);
         checkOutput("ovr_valid", r8_valid, cyc >= 8 && cyc <= 14);
         checkOutput("ovr_last", r8_last, cyc == 14);
         checkOutput("ovr_flag", r8_overrun, cyc >= 11);
         if (cyc >= 8 && cyc <= 14)
            checkWord("ovr_data", r8_data, {q1f(cyc - 1), q0f(cyc - 1)});
         tick();
      end

      // Reset during the second word of a BL4 CL3 burst
      cas_lat = 4'd3;
      doReset();
      for (int k = 0; k < 8; k++) begin
         applyStimulus(cyc == 0);
         checkOutput("mid_valid", r4_valid, cyc == 6 || cyc == 7);
         if (k < 7) tick();
      end
      checkWord("mid_data_pre", r4_data, {q1f(6), q0f(6)});
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_valid", r4_valid, 1'b0);
      checkOutput("mid_rst_last", r4_last, 1'b0);
      checkOutput("mid_rst_busy", r4_busy, 1'b0);
      checkOutput("mid_rst_ovr", r4_overrun, 1'b0);
      checkWord("mid_rst_data", r4_data, 32'h0);
      rd_cmd = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      cyc   = 0;
      for (int k = 0; k < 12; k++) begin
         applyStimulus(cyc == 2);
         checkOutput("post_valid", r4_valid, cyc == 8 || cyc == 9);
         checkOutput("post_last", r4_last, cyc == 9);
         checkOutput("post_ovr", r4_overrun, 1'b0);
         if (cyc == 8 || cyc == 9)
            checkWord("post_data", r4_data, {q1f(cyc - 1), q0f(cyc - 1)});
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
